// File: rtl/ia_enc_pkg.sv
// Shared types and constants for the zero-compressing activation encoder.
package ia_enc_pkg;

  localparam int unsigned MAX_CH = 32;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CIDX_W = 5;
  localparam int unsigned LEN_W  = 6;

  typedef struct packed {
    logic signed [DATA_W-1:0] data;
    logic [CIDX_W-1:0]        c_idx;
    logic                     last;
    logic                     is_null;
    logic [LEN_W-1:0]         len;
  } entry_t;

  typedef enum logic {
    S_RUN,
    S_DROP
  } state_e;

  // 17-bit magnitude so that -32768 maps to +32768 instead of wrapping.
  function automatic logic [DATA_W:0] abs_mag(input logic signed [DATA_W-1:0] v);
    logic [DATA_W:0] ext;
    ext = {v[DATA_W-1], v};
    return ext[DATA_W] ? (~ext + 17'd1) : ext;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags; push ignored when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 29,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push, pop;

  assign push = i_push && !full_q;
  assign pop  = i_pop && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d   = (cnt_d == (AW+1)'(DEPTH));
    empty_d  = (cnt_d == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_full  = full_q;
  assign o_empty = empty_q;

endmodule

// File: rtl/ia_zero_compressor.sv
// Dense-to-sparse activation encoder: drops zeros, tags kept values with their channel index.
// Define IA_ENC_THRESH_EN to replace exact-zero dropping with a magnitude threshold (i_thresh).
module ia_zero_compressor
  import ia_enc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_CH     = ia_enc_pkg::MAX_CH
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic signed [15:0] i_data,
  input  logic               i_last,
`ifdef IA_ENC_THRESH_EN
  input  logic [14:0]        i_thresh,
`endif
  output logic               o_valid,
  input  logic               i_ready,
  output logic signed [15:0] o_data,
  output logic [4:0]         o_c_idx,
  output logic               o_last,
  output logic               o_null,
  output logic [5:0]         o_len,
  output logic               o_overflow,
  output logic [15:0]        o_fiber_cnt
);

  state_e      state_q, state_d;
  logic [5:0]  ch_cnt_q, ch_cnt_d;
  logic [5:0]  nz_cnt_q, nz_cnt_d;
  logic        ovf_q, ovf_d;
  logic [15:0] fiber_cnt_q, fiber_cnt_d;

  logic   accept, keep, push, fifo_full, fifo_empty;
  entry_t push_entry, head;

  assign accept = i_valid && !fifo_full;

`ifdef IA_ENC_THRESH_EN
  assign keep = abs_mag(i_data) > {2'b00, i_thresh};
`else
  assign keep = (i_data != '0);
`endif

  always_comb begin
    state_d     = state_q;
    ch_cnt_d    = ch_cnt_q;
    nz_cnt_d    = nz_cnt_q;
    ovf_d       = ovf_q;
    fiber_cnt_d = fiber_cnt_q;
    push        = 1'b0;
    push_entry  = '0;

    if (accept) begin
      // Every fiber-closing path emits a terminator unless a kept value carries last itself.
      if (state_q == S_DROP || ch_cnt_q == 6'(MAX_CH)) begin
        if (i_last) begin
          push               = 1'b1;
          push_entry.last    = 1'b1;
          push_entry.is_null = 1'b1;
          push_entry.len     = nz_cnt_q;
          ch_cnt_d           = '0;
          nz_cnt_d           = '0;
          fiber_cnt_d        = fiber_cnt_q + 16'd1;
          state_d            = S_RUN;
        end else begin
          ovf_d   = 1'b1;
          state_d = S_DROP;
        end
      end else begin
        if (keep) begin
          push             = 1'b1;
          push_entry.data  = i_data;
          push_entry.c_idx = ch_cnt_q[4:0];
          push_entry.last  = i_last;
          push_entry.len   = nz_cnt_q + 6'd1;
          nz_cnt_d         = nz_cnt_q + 6'd1;
        end else if (i_last) begin
          push               = 1'b1;
          push_entry.last    = 1'b1;
          push_entry.is_null = 1'b1;
          push_entry.len     = nz_cnt_q;
        end
        ch_cnt_d = ch_cnt_q + 6'd1;
        if (i_last) begin
          ch_cnt_d    = '0;
          nz_cnt_d    = '0;
          fiber_cnt_d = fiber_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_RUN;
      ch_cnt_q    <= '0;
      nz_cnt_q    <= '0;
      ovf_q       <= 1'b0;
      fiber_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_cnt_q    <= ch_cnt_d;
      nz_cnt_q    <= nz_cnt_d;
      ovf_q       <= ovf_d;
      fiber_cnt_q <= fiber_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (push),
    .i_wdata(push_entry),
    .i_pop  (i_ready),
    .o_rdata(head),
    .o_full (fifo_full),
    .o_empty(fifo_empty)
  );

  // FIFO storage is not reset, so the payload is masked while nothing is valid.
  always_comb begin
    o_ready     = !fifo_full;
    o_valid     = !fifo_empty;
    o_data      = o_valid ? head.data : '0;
    o_c_idx     = o_valid ? head.c_idx : '0;
    o_last      = o_valid && head.last;
    o_null      = o_valid && head.is_null;
    o_len       = o_valid ? head.len : '0;
    o_overflow  = ovf_q;
    o_fiber_cnt = fiber_cnt_q;
  end

endmodule

// File: tb/tb_ia_zero_compressor.sv
// Randomised self-checking bench for ia_zero_compressor against a queue-based reference model.
module tb_ia_zero_compressor;

  localparam int unsigned DEPTH = 8;
  localparam int          MAXC  = 32;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_last, i_ready;
  logic [15:0] i_data;
  logic [14:0] i_thresh;
  logic        o_ready, o_valid, o_last, o_null, o_overflow;
  logic [15:0] o_data, o_fiber_cnt;
  logic [4:0]  o_c_idx;
  logic [5:0]  o_len;

  always #5 clk = ~clk;

  ia_zero_compressor #(
    .FIFO_DEPTH(DEPTH),
    .MAX_CH    (MAXC)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .i_last     (i_last),
`ifdef IA_ENC_THRESH_EN
    .i_thresh   (i_thresh),
`endif
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_c_idx    (o_c_idx),
    .o_last     (o_last),
    .o_null     (o_null),
    .o_len      (o_len),
    .o_overflow (o_overflow),
    .o_fiber_cnt(o_fiber_cnt)
  );

  typedef struct {
    logic [15:0] data;
    logic [4:0]  c_idx;
    logic        last;
    logic        nul;
    logic [5:0]  len;
  } exp_t;

  exp_t        exp_q[$];
  int          m_ch, m_nz;
  bit          m_dropping, m_ovf;
  logic [15:0] m_fibers;
  int          ready_mode;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_keep(input logic [15:0] d);
    int v;
    v = int'($signed(d));
`ifdef IA_ENC_THRESH_EN
    if (v < 0) v = -v;
    return v > int'(i_thresh);
`else
    return v != 0;
`endif
  endfunction

  function automatic void push_term();
    exp_t e;
    e.data = '0; e.c_idx = '0; e.last = 1'b1; e.nul = 1'b1; e.len = 6'(m_nz);
    exp_q.push_back(e);
  endfunction

  function automatic void close_fiber();
    m_ch = 0;
    m_nz = 0;
    m_dropping = 0;
    m_fibers = m_fibers + 16'd1;
  endfunction

  // One accepted dense element, following the encoding rules directly.
  function automatic void model_elem(input logic [15:0] d, input logic l);
    exp_t e;
    if (m_dropping || m_ch >= MAXC) begin
      if (l) begin
        push_term();
        close_fiber();
      end else begin
        m_ovf = 1;
        m_dropping = 1;
      end
    end else begin
      if (model_keep(d)) begin
        m_nz++;
        e.data = d; e.c_idx = 5'(m_ch); e.last = l; e.nul = 1'b0; e.len = 6'(m_nz);
        exp_q.push_back(e);
      end else if (l) begin
        push_term();
      end
      m_ch++;
      if (l) close_fiber();
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_ch = 0; m_nz = 0; m_dropping = 0; m_ovf = 0; m_fibers = '0;
  endfunction

  function automatic logic pick_ready();
    if (ready_mode == 0) return 1'b0;
    if (ready_mode == 1) return 1'b1;
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic step(input logic v, input logic [15:0] d, input logic l, output logic acc);
    bit pop;
    i_valid = v; i_data = d; i_last = l; i_ready = pick_ready();
    @(negedge clk);
    check("o_valid", o_valid, exp_q.size() != 0);
    check("o_ready", o_ready, exp_q.size() < DEPTH);
    check("o_overflow", o_overflow, m_ovf);
    check("o_fiber_cnt", o_fiber_cnt, m_fibers);
    if (exp_q.size() != 0) begin
      check("o_data", o_data, exp_q[0].data);
      check("o_c_idx", o_c_idx, exp_q[0].c_idx);
      check("o_last", o_last, exp_q[0].last);
      check("o_null", o_null, exp_q[0].nul);
      check("o_len", o_len, exp_q[0].len);
    end
    acc = v && (exp_q.size() < DEPTH);
    pop = (exp_q.size() != 0) && i_ready;
    if (pop) void'(exp_q.pop_front());
    if (acc) model_elem(d, l);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    logic acc;
    int n = 0;
    do begin
      step(1'b1, d, l, acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain();
    logic acc;
    int n = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && n < 100) begin
      step(1'b0, 16'd0, 1'b0, acc);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    step(1'b0, 16'd0, 1'b0, acc);
  endtask

  task automatic reset_and_check(input string tag);
    i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check({tag, "_valid"}, o_valid, 1'b0);
    check({tag, "_ready"}, o_ready, 1'b1);
    check({tag, "_data"}, o_data, 16'd0);
    check({tag, "_cidx"}, o_c_idx, 5'd0);
    check({tag, "_last"}, o_last, 1'b0);
    check({tag, "_null"}, o_null, 1'b0);
    check({tag, "_len"}, o_len, 6'd0);
    check({tag, "_ovf"}, o_overflow, 1'b0);
    check({tag, "_fcnt"}, o_fiber_cnt, 16'd0);
    i_rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int r;
    logic [15:0] d;
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_ready = 1'b0; i_thresh = '0;
    ready_mode = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_and_check("rst");

    // [0, 5, 0, -3]
    send(16'd0, 1'b0); send(16'd5, 1'b0); send(16'd0, 1'b0); send(-16'sd3, 1'b1);
    drain();
    check("t1_fibers", o_fiber_cnt, 16'd1);

    // [7, 0, 0] -> value then terminator with len 1
    send(16'd7, 1'b0); send(16'd0, 1'b0); send(16'd0, 1'b1);
    drain();

    // all-zero fiber of 8
    for (int i = 0; i < 8; i++) send(16'd0, 1'(i == 7));
    drain();
    check("t3_fibers", o_fiber_cnt, 16'd3);

    // backpressure: 8 accepts fill the FIFO
    ready_mode = 0;
    for (int i = 0; i < 8; i++) send(16'(i + 1), 1'b0);
    check("t4_full_ready", o_ready, 1'b0);
    ready_mode = 1;
    send(16'd9, 1'b0); send(16'd10, 1'b1);
    drain();

    // overflow: 40 ones in one fiber, then a normal fiber
    ready_mode = 2;
    for (int i = 0; i < 40; i++) send(16'd1, 1'(i == 39));
    drain();
    check("t5_overflow", o_overflow, 1'b1);
    send(16'd0, 1'b0); send(16'd2, 1'b1);
    drain();

`ifdef IA_ENC_THRESH_EN
    i_thresh = 15'd4;
    send(16'd3, 1'b0); send(-16'sd4, 1'b0); send(16'd5, 1'b0); send(16'h8000, 1'b1);
    drain();
`endif

    // randomised fibers, lengths straddling the channel limit
    for (int f = 0; f < 30; f++) begin
      ready_mode = 2;
`ifdef IA_ENC_THRESH_EN
      i_thresh = 15'($urandom_range(0, 8));
`endif
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(30, 40) : $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r < 4) d = 16'd0;
        else if (r < 8) d = 16'($urandom_range(0, 16)) - 16'd8;
        else if (r == 8) d = 16'h8000;
        else d = 16'($urandom);
        send(d, 1'(i == len - 1));
      end
    end
    drain();

    // reset in the middle of a fiber with entries queued
    ready_mode = 0;
    send(16'd3, 1'b0); send(16'd0, 1'b0); send(16'd4, 1'b0);
    reset_and_check("midrst");
    ready_mode = 1;
`ifdef IA_ENC_THRESH_EN
    i_thresh = '0;
`endif
    send(16'd0, 1'b0); send(16'd5, 1'b1);
    drain();
    check("post_rst_fibers", o_fiber_cnt, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
